// File: rtl/pill_counter.sv
// pill_counter: debounced pill-drop counter with a BCD display, a timed bottle-swap
// hold and a sticky flag for pills that arrive while counting is suspended.
module pill_counter #(
  parameter int DEB_CYCLES  = 3,
  parameter int SWAP_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN_work,
  input  logic       isWork,
  input  logic       pill_in,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic       bottle_full,
  output logic       cfg_err,
  output logic       lost
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(SWAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FILL, SWAP} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q, deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
  logic [SW-1:0] swap_cnt_q, swap_cnt_d;
  logic [3:0] now_l_q, now_l_d, now_h_q, now_h_d, max_l_q, max_l_d, max_h_q, max_h_d;
  logic [3:0] inc_l, inc_h;
  logic full_q, full_d, lost_q, lost_d;
  logic run, pill_evt, deb_hit, at_max, swap_done, counting;
  assign run       = !EN_work && isWork;
  assign cfg_err   = (maxL == 4'd0 && maxH == 4'd0) || maxL > 4'd9 || maxH > 4'd9;
  // a disagreeing sample that breaks a run restarts the stability count
  assign deb_inc   = (sync2_q == deb_q) ? '0 : deb_cnt_q + 1'b1;
  assign deb_hit   = deb_inc == DW'(DEB_CYCLES);
  assign pill_evt  = deb_q && !deb_prev_q;
  assign inc_l     = (now_l_q == 4'd9) ? 4'd0 : now_l_q + 4'd1;
  assign inc_h     = (now_l_q != 4'd9) ? now_h_q : (now_h_q == 4'd9) ? 4'd0 : now_h_q + 4'd1;
  assign at_max    = {inc_h, inc_l} == {max_h_q, max_l_q};
  assign swap_done = swap_cnt_q == SW'(SWAP_CYCLES - 1);
  assign counting  = run && state_q == FILL;
  assign nowL        = now_l_q;
  assign nowH        = now_h_q;
  assign bottle_full = full_q;
  assign lost        = lost_q;
  always_comb begin
    deb_cnt_d  = deb_hit ? '0 : deb_inc;
    deb_d      = deb_hit ? sync2_q : deb_q;
    state_d    = state_q;
    now_l_d    = now_l_q;
    now_h_d    = now_h_q;
    max_l_d    = max_l_q;
    max_h_d    = max_h_q;
    swap_cnt_d = swap_cnt_q;
    full_d     = 1'b0;
    lost_d     = lost_q || (pill_evt && !counting);
    if (EN_work) begin
      state_d    = IDLE;
      now_l_d    = 4'd0;
      now_h_d    = 4'd0;
      swap_cnt_d = '0;
      lost_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (run && !cfg_err) begin
          state_d = FILL;
          max_l_d = maxL;
          max_h_d = maxH;
        end
        FILL: if (pill_evt && run) begin
          now_l_d = inc_l;
          now_h_d = inc_h;
          if (at_max) begin
            state_d    = SWAP;
            full_d     = 1'b1;
            swap_cnt_d = '0;
          end
        end
        SWAP: if (swap_done) begin
          state_d = run ? FILL : IDLE;
          now_l_d = 4'd0;
          now_h_d = 4'd0;
        end else begin
          swap_cnt_d = swap_cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      now_l_q    <= 4'd0;
      now_h_q    <= 4'd0;
      max_l_q    <= 4'd0;
      max_h_q    <= 4'd0;
      swap_cnt_q <= '0;
      full_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sync1_q    <= pill_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      now_l_q    <= now_l_d;
      now_h_q    <= now_h_d;
      max_l_q    <= max_l_d;
      max_h_q    <= max_h_d;
      swap_cnt_q <= swap_cnt_d;
      full_q     <= full_d;
      lost_q     <= lost_d;
    end
  end
endmodule

// File: tb/tb_pill_counter.sv
// tb_pill_counter: scenario tasks plus randomized traffic, all checked against a
// decimal/window-based reference model of the pill counter.
module tb_pill_counter;
  localparam int DEB = 3;
  localparam int SWP = 8;
  localparam int S_IDLE = 0, S_FILL = 1, S_SWAP = 2;
  logic CLK = 1'b0, RST = 1'b1, EN_work = 1'b1, isWork = 1'b0, pill_in = 1'b0;
  logic [3:0] maxL = 4'd0, maxH = 4'd0;
  logic [3:0] nowL, nowH;
  logic bottle_full, cfg_err, lost;
  int n_checks = 0, n_pass = 0;
  int m_cnt, m_mx, m_left, m_st;
  bit m_bf, m_lost, m_deb, m_rise;
  bit [7:0] raw_h;

  pill_counter #(.DEB_CYCLES(DEB), .SWAP_CYCLES(SWP)) dut (
    .CLK(CLK), .RST(RST), .EN_work(EN_work), .isWork(isWork), .pill_in(pill_in),
    .maxL(maxL), .maxH(maxH), .nowL(nowL), .nowH(nowH),
    .bottle_full(bottle_full), .cfg_err(cfg_err), .lost(lost)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_cnt = 0; m_mx = 0; m_left = 0; m_st = S_IDLE;
    m_bf = 0; m_lost = 0; m_deb = 0; m_rise = 0; raw_h = '0;
  endfunction

  function automatic bit cfg_bad();
    return (int'(maxH) * 10 + int'(maxL) == 0) || maxL > 4'd9 || maxH > 4'd9;
  endfunction

  // One clock of the reference: decimal count, countdown swap timer, and a debouncer
  // expressed as "the last DEB synchronized samples all agree".
  function automatic void model_step();
    bit evt, run, stable;
    if (RST) begin
      model_reset();
      return;
    end
    evt = m_rise;
    run = !EN_work && isWork;
    m_bf = 0;
    if (EN_work) begin
      m_st = S_IDLE; m_cnt = 0; m_lost = 0; m_left = 0;
    end else if (m_st == S_IDLE) begin
      if (evt) m_lost = 1;
      if (run && !cfg_bad()) begin
        m_st = S_FILL;
        m_mx = int'(maxH) * 10 + int'(maxL);
      end
    end else if (m_st == S_FILL) begin
      if (evt && run) begin
        m_cnt++;
        if (m_cnt == m_mx) begin
          m_st = S_SWAP; m_bf = 1; m_left = SWP;
        end
      end else if (evt) m_lost = 1;
    end else begin
      if (evt) m_lost = 1;
      m_left--;
      if (m_left == 0) begin
        m_cnt = 0;
        m_st = run ? S_FILL : S_IDLE;
      end
    end
    stable = 1;
    for (int i = 2; i <= DEB; i++) if (raw_h[i] != raw_h[1]) stable = 0;
    m_rise = stable && raw_h[1] && !m_deb;
    if (stable) m_deb = raw_h[1];
    raw_h = {raw_h[6:0], pill_in};
  endfunction

  function automatic logic [10:0] expected();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), m_bf, m_lost, cfg_bad()};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    model_reset();
    RST = 1'b1; EN_work = 1'b0; isWork = 1'b0; pill_in = 1'b0; maxH = 4'd1; maxL = 4'd2;
    repeat (2) tick();
    n_checks++;
    if ({nowH, nowL, bottle_full, lost} !== 10'b0)
      $display("FAIL reset_state: got %b want 0000000000", {nowH, nowL, bottle_full, lost});
    else n_pass++;
    n_checks++;
    if (cfg_err !== 1'b0) $display("FAIL reset_cfg: got %b want 0", cfg_err);
    else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_fill_12();
    int prev = 0, v, n_inc = 0, n_bf = 0, peak = 0;
    isWork = 1'b1; EN_work = 1'b0; maxH = 4'd1; maxL = 4'd2;
    for (int c = 0; c < 136; c++) begin
      pill_in = c < 120 && c % 10 < 5;
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL fill12 c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
      v = int'(nowH) * 10 + int'(nowL);
      if (v == prev + 1) n_inc++;
      if (v > peak) peak = v;
      n_bf += int'(bottle_full);
      prev = v;
    end
    n_checks++;
    if (n_inc !== 12 || peak !== 12) $display("FAIL fill12_steps: got %0d steps peak %0d want 12 steps peak 12", n_inc, peak);
    else n_pass++;
    n_checks++;
    if (n_bf !== 1) $display("FAIL fill12_full_pulses: got %0d want 1", n_bf);
    else n_pass++;
    n_checks++;
    if ({nowH, nowL} !== 8'h00) $display("FAIL fill12_after_swap: got %h want 00", {nowH, nowL});
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [39:0] pat = 40'b11000000_10110110_11111111_00000000_00000000;
    for (int c = 0; c < 40; c++) begin
      pill_in = pat[39 - c];
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL glitch c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
    end
    n_checks++;
    if ({nowH, nowL} !== 8'h01) $display("FAIL glitch_count: got %h want 01", {nowH, nowL});
    else n_pass++;
  endtask

  task automatic test_swap_lost();
    int v, peak = 0;
    EN_work = 1'b1; maxH = 4'd0; maxL = 4'd5;
    tick();
    EN_work = 1'b0;
    for (int c = 0; c < 56; c++) begin
      pill_in = c < 36 && c % 6 < 3;
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL swap c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
      v = int'(nowH) * 10 + int'(nowL);
      if (v > peak) peak = v;
    end
    n_checks++;
    if (peak !== 5 || lost !== 1'b1 || {nowH, nowL} !== 8'h00)
      $display("FAIL swap_lost: got peak %0d lost %b now %h want peak 5 lost 1 now 00", peak, lost, {nowH, nowL});
    else n_pass++;
  endtask

  task automatic test_pause();
    EN_work = 1'b1; maxH = 4'd1; maxL = 4'd2;
    tick();
    EN_work = 1'b0;
    for (int c = 0; c < 104; c++) begin
      pill_in = c % 8 < 4 && (c < 56 || (c >= 64 && c < 80) || (c >= 88 && c < 96));
      isWork = !(c >= 64 && c < 88);
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL pause c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
      if (c == 63) begin
        n_checks++;
        if ({nowH, nowL, lost} !== 9'h0E) $display("FAIL pause_before: got now %h lost %b want 07 0", {nowH, nowL}, lost);
        else n_pass++;
      end
    end
    n_checks++;
    if ({nowH, nowL, lost} !== 9'h011) $display("FAIL pause_resume: got now %h lost %b want 08 1", {nowH, nowL}, lost);
    else n_pass++;
    EN_work = 1'b1;
    tick();
    n_checks++;
    if ({nowH, nowL, lost} !== 9'h000) $display("FAIL pause_setting: got now %h lost %b want 00 0", {nowH, nowL}, lost);
    else n_pass++;
  endtask

  task automatic test_cfg();
    int v, peak = 0, n_bf = 0;
    EN_work = 1'b1; maxH = 4'd0; maxL = 4'd0;
    tick();
    n_checks++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_zero: got %b want 1", cfg_err);
    else n_pass++;
    EN_work = 1'b0; isWork = 1'b1;
    repeat (3) tick();
    maxL = 4'hA;
    tick();
    n_checks++;
    if (cfg_err !== 1'b1 || {nowH, nowL} !== 8'h00) $display("FAIL cfg_digit: got cfg %b now %h want 1 00", cfg_err, {nowH, nowL});
    else n_pass++;
    repeat (3) tick();
    maxL = 4'd3;
    tick();
    for (int c = 0; c < 40; c++) begin
      pill_in = c < 24 && c % 8 < 4;
      if (c == 12) begin maxH = 4'd2; maxL = 4'd0; end
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL cfg c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
      v = int'(nowH) * 10 + int'(nowL);
      if (v > peak) peak = v;
      n_bf += int'(bottle_full);
    end
    n_checks++;
    if (peak !== 3 || n_bf !== 1 || {nowH, nowL} !== 8'h00)
      $display("FAIL cfg_old_max: got peak %0d fulls %0d now %h want 3 1 00", peak, n_bf, {nowH, nowL});
    else n_pass++;
  endtask

  task automatic test_random();
    int hold = 0, v;
    EN_work = 1'b0; isWork = 1'b1; maxH = 4'd0; maxL = 4'd4;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        pill_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 29) == 0) isWork = ~isWork;
      EN_work = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 39) == 0) begin
        v = $urandom_range(1, 15);
        maxH = 4'(v / 10);
        maxL = 4'(v % 10);
        if ($urandom_range(0, 7) == 0) maxL = 4'($urandom_range(10, 15));
      end
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL random c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
    end
    pill_in = 1'b0; EN_work = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_async_reset();
    EN_work = 1'b1; maxH = 4'd2; maxL = 4'd0;
    tick();
    EN_work = 1'b0; isWork = 1'b1;
    for (int c = 0; c < 120; c++) begin
      pill_in = c % 8 < 4;
      tick();
    end
    n_checks++;
    if ({nowH, nowL} !== 8'h15) $display("FAIL areset_pre: got %h want 15", {nowH, nowL});
    else n_pass++;
    #2 RST = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({nowH, nowL, bottle_full, lost} !== 10'b0)
      $display("FAIL areset_immediate: got %b want 0000000000", {nowH, nowL, bottle_full, lost});
    else n_pass++;
    tick();
    RST = 1'b0; pill_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({nowH, nowL, bottle_full, lost, cfg_err} !== expected())
        $display("FAIL areset_latency c%0d: got %b want %b", c, {nowH, nowL, bottle_full, lost, cfg_err}, expected());
      else n_pass++;
    end
    n_checks++;
    if ({nowH, nowL} !== 8'h01) $display("FAIL areset_first_count: got %h want 01", {nowH, nowL});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_12();
    test_glitch();
    test_swap_lost();
    test_pause();
    test_cfg();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
